req_retry_ctrl: RTL and testbench

//  Command-side sequencer directly upstream of the req/ack handshake FSM. It accepts one

---
 rtl/req_retry_ctrl_pkg.sv | 40 ++++
 rtl/req_retry_ctrl_if.sv | 37 +++
 rtl/req_retry_ctrl_backoff_timer.sv | 40 ++++
 rtl/req_retry_ctrl.sv | 158 +++++++++++++++
 tb/tb_req_retry_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/req_retry_ctrl_pkg.sv
// Shared types and helpers for the request retry controller.
//   status_t    : final completion status reported on the done channel
//   state_t     : sequencer FSM state encoding
//   backoff_len : saturating exponential backoff length for a given attempt number
package req_retry_ctrl_pkg;

  typedef enum logic [1:0] {
    StatusOk      = 2'd0,
    StatusFail    = 2'd1,
    StatusAborted = 2'd2,
    StatusTimeout = 2'd3
  } status_t;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLaunch  = 3'd1,
    StWait    = 3'd2,
    StBackoff = 3'd3,
    StReport  = 3'd4
  } state_t;

  // Backoff before retry number `attempt` is base << (attempt-1), capped at `cap`.
  // `width` is the counter width holding `cap`; any shift of that size or more
  // must overflow, so it saturates without evaluating the shift.
  function automatic int unsigned backoff_len(int unsigned attempt, int unsigned base,
                                              int unsigned cap, int unsigned width);
    int unsigned shift;
    logic [63:0] wide;
    shift = (attempt == 0) ? 0 : attempt - 1;
    if (shift >= width) begin
      return cap;
    end
    wide = 64'(base) << shift;
    if (wide > 64'(cap)) begin
      return cap;
    end
    return wide[31:0];
  endfunction

endpackage

// File: rtl/req_retry_ctrl_if.sv
// Bundles the command, downstream-FSM and completion handshakes of req_retry_ctrl.
//   cmd_valid/cmd_ready        : command request channel
//   abort                      : cancel request (level)
//   start/ok/error             : pulse interface to the downstream req/ack FSM
//   done_valid/done_ready      : completion channel, done_status + done_attempts
//   proto_err                  : protocol violation pulse
// Modports: slave = the controller, master = its environment.
interface req_retry_ctrl_if
  import req_retry_ctrl_pkg::*;
#(
  parameter int unsigned MAX_RETRY = 3
);
  localparam int unsigned AttW = $clog2(MAX_RETRY + 2);

  logic            cmd_valid;
  logic            cmd_ready;
  logic            abort;
  logic            start;
  logic            ok;
  logic            error;
  logic            done_valid;
  logic            done_ready;
  status_t         done_status;
  logic [AttW-1:0] done_attempts;
  logic            proto_err;

  modport master (
    output cmd_valid, abort, ok, error, done_ready,
    input  cmd_ready, start, done_valid, done_status, done_attempts, proto_err
  );

  modport slave (
    input  cmd_valid, abort, ok, error, done_ready,
    output cmd_ready, start, done_valid, done_status, done_attempts, proto_err
  );

endinterface

// File: rtl/req_retry_ctrl_backoff_timer.sv
// Down-counter used for the retry backoff interval.
//   clk, rstn : clock, synchronous active-low reset
//   load      : load load_val (a zero load is promoted to 1 so a wait always lasts >=1 cycle)
//   load_val  : backoff length in cycles
//   en        : counting enabled (controller is in BACKOFF)
//   expire    : high in the last enabled cycle of the interval
module req_retry_ctrl_backoff_timer #(
  parameter int unsigned Width = 7
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             en,
  output logic             expire
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = (load_val == '0) ? Width'(1) : load_val;
    end else if (en && (count_q > Width'(1))) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Count runs L..1, so the interval spans exactly L enabled cycles.
  assign expire = en && (count_q <= Width'(1));

endmodule

// File: rtl/req_retry_ctrl.sv
// Command-side sequencer in front of the req/ack handshake FSM. Accepts a command, pulses
// start, waits for ok/error, retries errors after an exponential backoff up to MAX_RETRY
// times and reports a final status on a valid/ready completion channel. A watchdog turns a
// silent downstream FSM into a TIMEOUT completion.
//   clk, rstn : clock, synchronous active-low reset
//   bus       : req_retry_ctrl_if.slave (cmd, abort, start/ok/error, done, proto_err)
module req_retry_ctrl
  import req_retry_ctrl_pkg::*;
#(
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned BACKOFF_BASE = 4,
  parameter int unsigned BACKOFF_MAX  = 64,
  parameter int unsigned WAIT_LIMIT   = 1024
) (
  input logic             clk,
  input logic             rstn,
  req_retry_ctrl_if.slave bus
);

  localparam int unsigned AttW = $clog2(MAX_RETRY + 2);
  localparam int unsigned BoW  = $clog2(BACKOFF_MAX) + 1;
  localparam int unsigned WdW  = $clog2(WAIT_LIMIT + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(WAIT_LIMIT - 1);

  state_t          state_q, state_d;
  status_t         status_q, status_d;
  logic [AttW-1:0] attempt_q, attempt_d;
  logic [WdW-1:0]  wdog_q, wdog_d;
  logic            abort_pend_q, abort_pend_d;
  logic            proto_err_q, proto_err_d;

  logic           bo_load;
  logic           bo_expire;
  logic [BoW-1:0] bo_len;

  assign bo_len = BoW'(backoff_len(32'(attempt_q), BACKOFF_BASE, BACKOFF_MAX, BoW));

  req_retry_ctrl_backoff_timer #(
    .Width (BoW)
  ) u_backoff_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (bo_load),
    .load_val (bo_len),
    .en       (state_q == StBackoff),
    .expire   (bo_expire)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= StIdle;
      status_q     <= StatusOk;
      attempt_q    <= '0;
      wdog_q       <= '0;
      abort_pend_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      attempt_q    <= attempt_d;
      wdog_q       <= wdog_d;
      abort_pend_q <= abort_pend_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    attempt_d    = attempt_q;
    wdog_d       = wdog_q;
    abort_pend_d = abort_pend_q;
    bo_load      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          attempt_d    = '0;
          abort_pend_d = 1'b0;
          state_d      = StLaunch;
        end
      end

      StLaunch: begin
        // The start pulse goes out regardless of abort; abort only arms the pending flag.
        attempt_d = attempt_q + AttW'(1);
        wdog_d    = '0;
        if (bus.abort) begin
          abort_pend_d = 1'b1;
        end
        state_d = StWait;
      end

      StWait: begin
        if (bus.abort) begin
          abort_pend_d = 1'b1;
        end
        // error takes priority over ok when both arrive together.
        if (bus.error) begin
          if (abort_pend_q || bus.abort) begin
            state_d  = StReport;
            status_d = StatusAborted;
          end else if (32'(attempt_q) <= MAX_RETRY) begin
            state_d = StBackoff;
            bo_load = 1'b1;
          end else begin
            state_d  = StReport;
            status_d = StatusFail;
          end
        end else if (bus.ok) begin
          // A completed attempt wins over a late abort.
          state_d  = StReport;
          status_d = StatusOk;
        end else if (wdog_q == WdLast) begin
          state_d  = StReport;
          status_d = StatusTimeout;
        end else begin
          wdog_d = wdog_q + WdW'(1);
        end
      end

      StBackoff: begin
        if (bus.abort) begin
          state_d  = StReport;
          status_d = StatusAborted;
        end else if (bo_expire) begin
          state_d = StLaunch;
        end
      end

      StReport: begin
        if (bus.done_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Simultaneous ok/error, or any response while no attempt is in flight.
    proto_err_d = (bus.ok && bus.error) || ((bus.ok || bus.error) && (state_q != StWait));
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    bus.cmd_ready     = (state_q == StIdle);
    bus.start         = (state_q == StLaunch);
    bus.done_valid    = (state_q == StReport);
    bus.done_status   = status_q;
    bus.done_attempts = attempt_q;
    bus.proto_err     = proto_err_q;
  end

endmodule

// File: tb/tb_req_retry_ctrl.sv
module tb_req_retry_ctrl;
  import req_retry_ctrl_pkg::*;

  localparam int unsigned MAX_RETRY    = 3;
  localparam int unsigned BACKOFF_BASE = 4;
  localparam int unsigned BACKOFF_MAX  = 64;
  localparam int unsigned WAIT_LIMIT   = 1024;

  localparam logic [1:0] R_OK   = 2'd0;
  localparam logic [1:0] R_ERR  = 2'd1;
  localparam logic [1:0] R_BOTH = 2'd2;
  localparam logic [1:0] R_NONE = 2'd3;

  typedef struct {
    logic [7:0] resp;        // 2 bits per attempt, attempt 1 in the LSBs
    int         delay;       // cycles from start to the response
    bit         abort_wait;  // pulse abort in the first WAIT cycle of attempt 1
    bit         abort_bo;    // pulse abort in the first BACKOFF cycle
    int         hold;        // cycles done_ready is held low
    status_t    exp_status;
    int         exp_attempts;
    int         exp_proto;
  } vec_t;

  typedef struct {
    status_t st;
    int      att;
  } exp_t;

  logic clk;
  logic rstn;
  int   checks = 0;
  int   failures = 0;
  int   start_cnt = 0;
  int   proto_cnt = 0;
  exp_t sb_q[$];
  vec_t vecs[9];

  req_retry_ctrl_if #(.MAX_RETRY(MAX_RETRY)) bus ();

  req_retry_ctrl #(
    .MAX_RETRY    (MAX_RETRY),
    .BACKOFF_BASE (BACKOFF_BASE),
    .BACKOFF_MAX  (BACKOFF_MAX),
    .WAIT_LIMIT   (WAIT_LIMIT)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int model_gap(int attempt);
    longint v;
    v = longint'(BACKOFF_BASE) << (attempt - 1);
    if (v > BACKOFF_MAX) v = BACKOFF_MAX;
    return int'(v) + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: count pulses and pop expectations on each completion handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      if (bus.start) start_cnt++;
      if (bus.proto_err) proto_cnt++;
      if (bus.done_valid && bus.done_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("done_status", int'(bus.done_status), int'(e.st));
          check("done_attempts", int'(bus.done_attempts), e.att);
        end
      end
    end
  end

  task automatic check_reset_vals(string tag);
    check({tag, "_cmd_ready"}, int'(bus.cmd_ready), 1);
    check({tag, "_start"}, int'(bus.start), 0);
    check({tag, "_done_valid"}, int'(bus.done_valid), 0);
    check({tag, "_done_status"}, int'(bus.done_status), int'(StatusOk));
    check({tag, "_done_attempts"}, int'(bus.done_attempts), 0);
    check({tag, "_proto_err"}, int'(bus.proto_err), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int         a;
    int         n;
    int         starts0;
    int         proto0;
    bit         fin;
    logic [1:0] r;
    starts0 = start_cnt;
    proto0  = proto_cnt;
    sb_q.push_back('{st: v.exp_status, att: v.exp_attempts});
    check("cmd_ready_idle", int'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check("accept_to_start", int'(bus.start), 1);
    a   = 0;
    fin = 1'b0;
    while (!fin) begin
      r = v.resp[2*a +: 2];
      if (r == R_NONE) begin
        n = 0;
        while (!bus.done_valid && n < int'(WAIT_LIMIT) + 20) begin
          tick();
          n++;
        end
        check("timeout_latency", n, int'(WAIT_LIMIT) + 1);
        fin = 1'b1;
      end else begin
        for (int k = 1; k <= v.delay; k++) begin
          tick();
          bus.abort = (k == 1) && v.abort_wait && (a == 0);
        end
        bus.ok    = (r == R_OK) || (r == R_BOTH);
        bus.error = (r == R_ERR) || (r == R_BOTH);
        tick();
        bus.ok    = 1'b0;
        bus.error = 1'b0;
        bus.abort = 1'b0;
        a++;
        if (r == R_OK) begin
          check("ok_to_done", int'(bus.done_valid), 1);
          fin = 1'b1;
        end else if (v.abort_wait) begin
          check("abort_wait_err_done", int'(bus.done_valid), 1);
          fin = 1'b1;
        end else if (v.abort_bo) begin
          check("in_backoff_no_done", int'(bus.done_valid), 0);
          bus.abort = 1'b1;
          tick();
          bus.abort = 1'b0;
          check("abort_bo_done", int'(bus.done_valid), 1);
          fin = 1'b1;
        end else if (a <= int'(MAX_RETRY)) begin
          n = 1;
          while (!bus.start && n < 300) begin
            tick();
            n++;
          end
          check("error_to_retry_start", n, model_gap(a));
        end else begin
          check("final_err_done", int'(bus.done_valid), 1);
          fin = 1'b1;
        end
      end
    end
    for (int h = 0; h < v.hold; h++) begin
      tick();
      check("hold_valid", int'(bus.done_valid), 1);
      check("hold_status", int'(bus.done_status), int'(v.exp_status));
      check("hold_attempts", int'(bus.done_attempts), v.exp_attempts);
    end
    bus.done_ready = 1'b1;
    tick();
    bus.done_ready = 1'b0;
    check("cmd_ready_after_done", int'(bus.cmd_ready), 1);
    check("done_valid_dropped", int'(bus.done_valid), 0);
    check("start_pulses", start_cnt - starts0, v.exp_attempts);
    check("proto_err_pulses", proto_cnt - proto0, v.exp_proto);
  endtask

  initial begin
    vecs[0] = '{resp: {R_NONE, R_NONE, R_NONE, R_OK}, delay: 3, abort_wait: 0, abort_bo: 0,
                hold: 0, exp_status: StatusOk, exp_attempts: 1, exp_proto: 0};
    vecs[1] = '{resp: {R_NONE, R_OK, R_ERR, R_ERR}, delay: 3, abort_wait: 0, abort_bo: 0,
                hold: 0, exp_status: StatusOk, exp_attempts: 3, exp_proto: 0};
    vecs[2] = '{resp: {R_ERR, R_ERR, R_ERR, R_ERR}, delay: 2, abort_wait: 0, abort_bo: 0,
                hold: 0, exp_status: StatusFail, exp_attempts: 4, exp_proto: 0};
    vecs[3] = '{resp: {R_NONE, R_NONE, R_NONE, R_ERR}, delay: 1, abort_wait: 0, abort_bo: 1,
                hold: 0, exp_status: StatusAborted, exp_attempts: 1, exp_proto: 0};
    vecs[4] = '{resp: {R_NONE, R_NONE, R_NONE, R_OK}, delay: 4, abort_wait: 1, abort_bo: 0,
                hold: 0, exp_status: StatusOk, exp_attempts: 1, exp_proto: 0};
    vecs[5] = '{resp: {R_NONE, R_NONE, R_NONE, R_NONE}, delay: 0, abort_wait: 0, abort_bo: 0,
                hold: 0, exp_status: StatusTimeout, exp_attempts: 1, exp_proto: 0};
    vecs[6] = '{resp: {R_NONE, R_NONE, R_OK, R_BOTH}, delay: 2, abort_wait: 0, abort_bo: 0,
                hold: 0, exp_status: StatusOk, exp_attempts: 2, exp_proto: 1};
    vecs[7] = '{resp: {R_NONE, R_NONE, R_NONE, R_OK}, delay: 1, abort_wait: 0, abort_bo: 0,
                hold: 10, exp_status: StatusOk, exp_attempts: 1, exp_proto: 0};
    vecs[8] = '{resp: {R_NONE, R_NONE, R_NONE, R_ERR}, delay: 3, abort_wait: 1, abort_bo: 0,
                hold: 0, exp_status: StatusAborted, exp_attempts: 1, exp_proto: 0};

    rstn           = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.abort      = 1'b0;
    bus.ok         = 1'b0;
    bus.error      = 1'b0;
    bus.done_ready = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset");
    rstn = 1'b1;
    tick();
    check_reset_vals("post_reset");

    foreach (vecs[i]) run_vec(vecs[i]);

    // ok outside WAIT: protocol error pulse, no state change.
    bus.ok = 1'b1;
    tick();
    bus.ok = 1'b0;
    check("idle_ok_proto_err", int'(bus.proto_err), 1);
    check("idle_ok_still_ready", int'(bus.cmd_ready), 1);
    tick();
    check("idle_ok_proto_err_pulse", int'(bus.proto_err), 0);

    // Reset while an attempt is in WAIT drops the command without a completion.
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    check("pre_reset_in_wait", int'(bus.cmd_ready), 0);
    rstn = 1'b0;
    tick();
    check_reset_vals("mid_reset");
    rstn = 1'b1;
    tick();
    run_vec(vecs[0]);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
